// File: rtl/spi_defs_pkg.sv
// Shared SPI definitions used by both the spictrl initiator and spi_target.
//   SPI_BITS       : bits per transfer
//   SPI_IDLE_BYTE  : default filler byte when nothing is queued for transmit
//   SPI_MODE       : {CPOL, CPHA}; both ends are built for mode 0
//   CNT_W          : bit-counter width
//   spi_state_e    : target link state
package spi_defs;
  localparam int             SPI_BITS      = 8;
  localparam logic [7:0]     SPI_IDLE_BYTE = 8'hFF;
  localparam logic [1:0]     SPI_MODE      = 2'b00;
  localparam int             CNT_W         = $clog2(SPI_BITS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous pad input plus an edge-detect flop.
//   clk, rst : system clock, async active-low reset
//   din      : raw pad input
//   level    : synchronized level
//   rise/fall: one-cycle edge strobes, decoded from two flops (glitch-free)
// RST_VAL sets the idle level the chain powers up at so no false edge fires
// when reset releases.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  =  level & ~prev;
  assign fall  = ~level &  prev;
endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with a byte-wide register interface.
//   clk, rst             : system clock, async active-low reset
//   txdata/txload        : write the transmit holding register
//   tx_full              : holding register occupied
//   tx_underrun          : pulse, a byte started with nothing queued
//   rxdata/rx_valid      : last received byte and its update strobe
//   rx_overrun           : pulse, byte landed before previous was acked
//   rx_ack               : consumer took rxdata
//   busy                 : link selected
//   spi_sck/mosi/ssel_n  : async pad inputs
//   spi_miso/spi_miso_oe : registered serial output and its pad enable
module spi_target
  import spi_defs::*;
#(
  parameter int                   SYNC_STAGES = 2,
  parameter logic [SPI_BITS-1:0]  IDLE_BYTE   = SPI_IDLE_BYTE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SPI_BITS-1:0] txdata,
  input  logic                txload,
  output logic                tx_full,
  output logic                tx_underrun,
  output logic [SPI_BITS-1:0] rxdata,
  output logic                rx_valid,
  output logic                rx_overrun,
  input  logic                rx_ack,
  output logic                busy,
  input  logic                spi_sck,
  input  logic                spi_mosi,
  input  logic                spi_ssel_n,
  output logic                spi_miso,
  output logic                spi_miso_oe
);
  // ---- pad synchronizers: index 0 = SCK, 1 = MOSI, 2 = SSEL_N ----
  localparam int             NIN      = 3;
  localparam logic [NIN-1:0] SYNC_RST = 3'b110;

  logic [NIN-1:0] pad_in, lvl, rise, fall;
  assign pad_in = {spi_ssel_n, spi_mosi, spi_sck};

  for (genvar g = 0; g < NIN; g++) begin : g_sync
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST[g])) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (pad_in[g]),
      .level(lvl[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  logic sck_rise, sck_fall, mosi_s, ssel_fall, ssel_rise;
  assign sck_rise  = rise[0];
  assign sck_fall  = fall[0];
  assign mosi_s    = lvl[1];
  assign ssel_fall = fall[2];
  assign ssel_rise = rise[2];

  logic unused_sync;
  assign unused_sync = ^{lvl[0], lvl[2], rise[1], fall[1]};

  // ---- state ----
  spi_state_e state, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (ssel_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (ssel_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---- control decode ----
  logic [CNT_W-1:0]      cnt;
  logic [SPI_BITS-1:0]   hold, tx_sh;
  logic [SPI_BITS-2:0]   rx_sh;
  logic                  rx_pend;
  logic                  active_go, start, bit_rise, bit_fall, done, reload;
  logic [SPI_BITS-1:0]   reload_byte;

  // SSEL release beats any SCK edge landing in the same cycle.
  assign active_go = (state == ST_ACTIVE) && !ssel_rise;
  assign start     = (state == ST_IDLE) && ssel_fall;
  assign bit_rise  = active_go && sck_rise;
  // Falls with cnt==0 are the lead-in fall or the fall after completion;
  // the freshly loaded MSB must stay on the line through them.
  assign bit_fall  = active_go && sck_fall && (cnt != '0);
  assign done      = bit_rise && (cnt == CNT_W'(SPI_BITS-1));
  assign reload    = start || done;
  // A txload landing on a reload bypasses the holding register.
  assign reload_byte = txload  ? txdata :
                       tx_full ? hold   : IDLE_BYTE;

  // ---- transmit side ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold        <= '0;
      tx_full     <= 1'b0;
      tx_underrun <= 1'b0;
      tx_sh       <= IDLE_BYTE;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
    end else begin
      if (txload) hold <= txdata;

      if (reload)      tx_full <= 1'b0;
      else if (txload) tx_full <= 1'b1;

      tx_underrun <= reload && !txload && !tx_full;

      if (reload)        tx_sh <= reload_byte;
      else if (bit_fall) tx_sh <= {tx_sh[SPI_BITS-2:0], 1'b1};

      // Pad follows the shift register MSB one cycle later while selected.
      spi_miso_oe <= (state_d == ST_ACTIVE);
      spi_miso    <= (state_d == ST_ACTIVE) ? tx_sh[SPI_BITS-1] : 1'b1;
    end
  end

  // ---- receive side ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      rx_sh      <= '0;
      rxdata     <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_pend    <= 1'b0;
    end else begin
      if (!active_go)    cnt <= '0;
      else if (sck_rise) cnt <= cnt + CNT_W'(1);

      if (bit_rise) rx_sh <= {rx_sh[SPI_BITS-3:0], mosi_s};
      if (done)     rxdata <= {rx_sh, mosi_s};

      rx_valid   <= done;
      // An ack in the completion cycle consumed the old byte in time.
      rx_overrun <= done && rx_pend && !rx_ack;

      if (done)        rx_pend <= 1'b1;
      else if (rx_ack) rx_pend <= 1'b0;
    end
  end

  assign busy = (state == ST_ACTIVE);
endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 target (peripheral) that answers `spictrl`, the on-chip SPI initiator, across a board or loopback link. SCK, MOSI and SSEL from the initiator are sampled on `clk` and processed one byte at a time, MSB first. The core presents a byte-wide register interface: a transmit holding register and a receive data register with a valid strobe. It is used for loopback self-test of `spictrl` and for an FPGA-hosted SPI peripheral.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per SPI input (≥2).
- `IDLE_BYTE`, 8'hFF: byte shifted out when no transmit byte is pending.
- `clk` in 1: system clock (25 MHz nominal).
- `rst` in 1: reset. **Asynchronous, active-low.** Deassertion is synchronous to `clk` externally.
- `txdata` in 8: byte to send.
- `txload` in 1: one-cycle strobe. Writes `txdata` into the holding register.
- `tx_full` out 1: holding register occupied.
- `tx_underrun` out 1: one-cycle pulse. A byte started with the holding register empty.
- `rxdata` out 8: last complete received byte. Held until the next byte completes.
- `rx_valid` out 1: one-cycle pulse when `rxdata` updates.
- `rx_overrun` out 1: one-cycle pulse. A byte completed while the previous `rx_valid` was not acknowledged.
- `rx_ack` in 1: consumer has taken `rxdata`.
- `busy` out 1: synchronized SSEL asserted.
- `spi_sck`, `spi_mosi`, `spi_ssel_n` in 1: asynchronous pad inputs.
- `spi_miso` out 1: serial data to the initiator.
- `spi_miso_oe` out 1: output enable for the MISO pad buffer.

## Operation
- **Reset values:** `spi_miso`=1, `spi_miso_oe`=0, `rxdata`=0. `tx_full`, `rx_valid`, `rx_overrun`, `tx_underrun` and `busy` are 0. Bit counter=0, shift register=`IDLE_BYTE`, rx pending=0.
- **Synchronization:** each SPI input passes through `SYNC_STAGES` flops plus one edge-detect flop. Edge-detect outputs are `sck_rise`, `sck_fall`, `ssel_fall` and `ssel_rise`.
- **States:** IDLE (SSEL high) and ACTIVE (SSEL low). In IDLE, `spi_miso_oe`=0 and the bit counter is held at 0.
- **IDLE→ACTIVE on `ssel_fall`:**
  - Load the shift register from the holding register if `tx_full`, and clear `tx_full`.
  - Otherwise load `IDLE_BYTE` and pulse `tx_underrun`.
  - Set `spi_miso_oe`=1 and drive shift register bit 7 to `spi_miso` on the next cycle.
- **`sck_rise` in ACTIVE:**
  - Shift `spi_mosi` (synchronized) into the rx shift register LSB.
  - Increment the 3-bit bit counter.
- **`sck_fall` in ACTIVE with counter ≠ 0:** shift the tx register left and drive the new bit 7. The counter=0 case (falls before the first rise, or after byte completion) leaves MISO unchanged.
- **Byte completion (8th `sck_rise`, counter wraps 7→0):**
  - `rxdata` takes the assembled byte; pulse `rx_valid`.
  - If rx pending is set, also pulse `rx_overrun`; the new byte overwrites the old one.
  - Set rx pending. It clears on `rx_ack`. If `rx_ack` and completion occur in the same cycle, pending stays set and there is no overrun.
  - Reload the tx shift register exactly as on `ssel_fall`, and drive the new MSB.
- **`txload`:** writes the holding register and sets `tx_full`. If `tx_full` is already set, the old byte is overwritten. When `txload` coincides with a reload, the reload takes the new `txdata` and `tx_full` ends at 0.
- **ACTIVE→IDLE on `ssel_rise`:**
  - The counter resets to 0 and any partial byte is discarded, with no `rx_valid`.
  - `spi_miso_oe`=0 and `spi_miso`=1.
  - The holding register is kept.
- **SSEL deassert and SCK edge in the same cycle:** SSEL wins, and the SCK edge is ignored.

## Timing
- Pad edge to internal action: `SYNC_STAGES`+1 `clk` cycles, which is 3 by default.
- `spi_miso` is registered. It updates at pad SCK fall + 4 `clk` by default.
- SCK high and low times must each be ≥ 2×(`SYNC_STAGES`+2) `clk` cycles. This is clk/16 at defaults, so `spictrl` slow mode qualifies and fast mode does not.
- SSEL fall to first SCK rise must be ≥ `SYNC_STAGES`+3 `clk` cycles.
- `rx_valid` asserts `SYNC_STAGES`+1 cycles after the 8th pad SCK rise and lasts exactly one cycle.
- Back-to-back bytes need no gap; the reload happens within the byte-completion cycle.

## Structure
- Shared package/header `spi_defs`: `SPI_IDLE_BYTE` default and `SPI_BITS`=8. Also the SPI mode constant, so `spictrl` and `spi_target` agree.
- Sub-module `spi_sync_edge`: N-stage synchronizer with registered rise/fall outputs and a configurable reset value (1 for SSEL and MOSI, 0 for SCK). It is instantiated three times.
- Top level holds the state, counter, shift registers and flags. Target size is about 200 lines of RTL.

## Test plan
- **Loopback at slow rate:** `spictrl` slow mode sends 8'h55 while the target has preloaded 8'hA3. Required: `rxdata`=8'h55 with one `rx_valid` pulse, and `spictrl` `rxdata`=8'hA3.
- **Underrun:** with no `txload`, SSEL falls. Required: `tx_underrun` pulses once and the initiator receives 8'hFF.
- **Back-to-back:** send three bytes 8'h01, 8'h80, 8'hFF without SSEL release, and do not assert `rx_ack` after the first. Required: three `rx_valid` pulses and `rx_overrun` on bytes 2 and 3.
- **Abort:** deassert SSEL after 5 SCK rises. Required: no `rx_valid`, `spi_miso_oe`→0 within 4 cycles, and the next full byte is received correctly.
- **Reset mid-byte:** assert `rst` low after 3 bits. Required: all outputs return to their reset values immediately. After release, an 8'hC3 transfer completes correctly.
- **Coincidence:** `txload` 8'h5A lands in the same cycle as byte completion with the holding register empty. Required: the next byte shifted out is 8'h5A, `tx_full`=0, and there is no `tx_underrun`.
